// File: rtl/dmem_arbiter_if.sv
// Request-side bundle shared by the processor (C) and the capture engine (S).
// Requesters connect through the master modport; dmem_arbiter uses the slave modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_wen;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              s_req;
  logic              s_lock;
  logic              s_wen;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;

  modport master (
    output c_req, c_wen, c_addr, c_wdata,
    output s_req, s_lock, s_wen, s_addr, s_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  s_gnt, s_rvalid, s_rdata
  );

  modport slave (
    input  c_req, c_wen, c_addr, c_wdata,
    input  s_req, s_lock, s_wen, s_addr, s_wdata,
    output c_gnt, c_rvalid, c_rdata,
    output s_gnt, s_rvalid, s_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-RAM port between processor (C) and capture engine (S).
// Default: C priority with S aging. Define DMEM_ARB_RR_EN for round-robin in IDLE/C_OWN.
module dmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dmem_arbiter_if.slave     bus_if,
  output logic              o_ram_wen,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data_in,
  input  logic [DATA_W-1:0] i_ram_data_out
);

  localparam int BURST_W = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, C_OWN, S_BURST} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_S} owner_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BURST_W-1:0]  r_burst_cnt;
  logic [BURST_W-1:0]  w_burst_cnt_nxt;
  owner_t              r_rd_owner;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W-1:0]   r_c_rdata;
  logic [DATA_W-1:0]   r_s_rdata;

  logic w_c_gnt;
  logic w_s_gnt;
  logic w_c_win;
  logic w_c_rvalid;
  logic w_s_rvalid;

`ifdef DMEM_ARB_RR_EN
  logic r_last_s;

  // On a tie the port granted most recently loses.
  always_comb w_c_win = bus_if.c_req && !(bus_if.s_req && !r_last_s);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_s <= 1'b1;
    end else if (w_c_gnt) begin
      r_last_s <= 1'b0;
    end else if (w_s_gnt) begin
      r_last_s <= 1'b1;
    end
  end
`else
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_wait_cnt;

  // A starved S (denied MAX_WAIT times) is forced ahead of C.
  always_comb w_c_win = bus_if.c_req &&
                        !(bus_if.s_req && (r_wait_cnt == WAIT_W'(MAX_WAIT)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_s_gnt) begin
      r_wait_cnt <= '0;
    end else if (bus_if.s_req && (r_wait_cnt != WAIT_W'(MAX_WAIT))) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`endif

  // Grant and next state; grants are forced low while reset is asserted.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    w_c_gnt         = 1'b0;
    w_s_gnt         = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        S_BURST: begin
          if (bus_if.s_req) begin
            w_s_gnt         = 1'b1;
            w_burst_cnt_nxt = r_burst_cnt + 1'b1;
          end
          if (!bus_if.s_lock ||
              (bus_if.s_req && (w_burst_cnt_nxt == BURST_W'(BURST_MAX)))) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          if (w_c_win) begin
            w_c_gnt     = 1'b1;
            w_state_nxt = C_OWN;
          end else if (bus_if.s_req) begin
            w_s_gnt = 1'b1;
            if (bus_if.s_lock && (BURST_MAX > 1)) begin
              w_state_nxt     = S_BURST;
              w_burst_cnt_nxt = BURST_W'(1);
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  // RAM side: granted port drives the bus; otherwise the last address/data hold.
  always_comb begin
    o_ram_wen     = 1'b0;
    o_ram_addr    = r_ram_addr;
    o_ram_data_in = r_ram_wdata;
    if (w_c_gnt) begin
      o_ram_wen     = bus_if.c_wen;
      o_ram_addr    = bus_if.c_addr;
      o_ram_data_in = bus_if.c_wdata;
    end else if (w_s_gnt) begin
      o_ram_wen     = bus_if.s_wen;
      o_ram_addr    = bus_if.s_addr;
      o_ram_data_in = bus_if.s_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_rd_owner  <= OWN_NONE;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_c_rdata   <= '0;
      r_s_rdata   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      if (w_c_gnt || w_s_gnt) begin
        r_ram_addr  <= o_ram_addr;
        r_ram_wdata <= o_ram_data_in;
      end
      if (w_c_gnt && !bus_if.c_wen) begin
        r_rd_owner <= OWN_C;
      end else if (w_s_gnt && !bus_if.s_wen) begin
        r_rd_owner <= OWN_S;
      end else begin
        r_rd_owner <= OWN_NONE;
      end
      if (w_c_rvalid) r_c_rdata <= i_ram_data_out;
      if (w_s_rvalid) r_s_rdata <= i_ram_data_out;
    end
  end

  // Read data is live from the RAM on the return cycle and held afterwards.
  assign w_c_rvalid = (r_rd_owner == OWN_C);
  assign w_s_rvalid = (r_rd_owner == OWN_S);

  assign bus_if.c_gnt    = w_c_gnt;
  assign bus_if.c_rvalid = w_c_rvalid;
  assign bus_if.c_rdata  = w_c_rvalid ? i_ram_data_out : r_c_rdata;
  assign bus_if.s_gnt    = w_s_gnt;
  assign bus_if.s_rvalid = w_s_rvalid;
  assign bus_if.s_rdata  = w_s_rvalid ? i_ram_data_out : r_s_rdata;

  a_one_grant : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                 !(w_c_gnt && w_s_gnt));

endmodule
